i2c_temp_poll_controller: RTL

Periodic temperature-sensor poller driving the I2C_Master command interface (go/rw/N_Byte/dev_add/R_Pointer) and writing a formatted ASCII reading into the LCD character RAM through the LCDI write port. It sits directly upstream of I2C_Master, in parallel with the Spartan-slave controller, and is enabled by the menu controller. Each poll issues one 2-byte register read (LM75-style 9-bit two's-complement value, 0.5 °C LSB), converts it to 7 characters and signals completion.

---
 rtl/i2c_temp_poll_controller.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_temp_poll_controller.sv
// Periodic LM75-style temperature poller: 2-byte I2C_Master read, 7-char ASCII reading into LCD RAM.
// Optional byte watchdog enabled by defining TEMP_WATCHDOG_EN.
module i2c_temp_poll_controller #(
    parameter int unsigned POLL_CYCLES = 50_000_000,
    parameter logic [7:0]  REG_PTR     = 8'h00,
    parameter logic [4:0]  LCD_BASE    = 5'd16
`ifdef TEMP_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 1_000_000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Controller_Enable,
    input  logic [6:0] Menu_SlaveAddr,
    input  logic       Master_Ready,
    input  logic       Master_Done,
    input  logic       Master_ACK,
    input  logic [7:0] Master_ReadData,
    output logic       Master_Go,
    output logic       Master_Stop,
    output logic       Master_RW,
    output logic [5:0] Master_NumOfBytes,
    output logic [6:0] Master_SlaveAddr,
    output logic [7:0] Master_SlaveRegAddr,
    output logic [7:0] Master_DataWriteReg,
    output logic [4:0] LCD_WADD,
    output logic [7:0] LCD_DIN,
    output logic       LCD_W,
    output logic       Controller_Done,
    output logic [8:0] temp_half,
    output logic       sensor_error
);
    localparam int unsigned PCW = 26;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_CYCLES - 1);
    localparam logic [PCW-1:0] POLL_MAX  = '1;
`ifdef TEMP_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
    logic [WDW-1:0] wdog_q, wdog_d;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_START, S_BYTE0, S_BYTE1, S_CONV, S_WRITE, S_DONE, S_ERR_WAIT
    } state_e;

    state_e         state_q, state_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     msb_q, msb_d;
    logic [19:0]    dd_q, dd_d;
    logic           neg_q, neg_d, frac_q, frac_d, err_q, err_d, abort_q, abort_d;
    logic [8:0]     temp_q, temp_d;
    logic           serr_q, serr_d;
    logic [6:0]     addr_q, addr_d;
    logic           go_q, go_d, stop_q, stop_d, lcdw_q, lcdw_d, done_q, done_d, rw_q;
    logic [5:0]     nb_q, nb_d;
    logic [7:0]     reg_q, reg_d, din_q, din_d;
    logic [4:0]     wadd_q, wadd_d;
    logic [8:0]     raw_c, abs_c;
    logic [7:0]     char_c;

    // One double-dabble iteration: bias BCD digits >= 5, then shift the whole register left.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

    assign raw_c = {msb_q, Master_ReadData[7]};
    assign abs_c = raw_c[8] ? (~raw_c + 9'd1) : raw_c;

    // Character for the current WRITE slot
    always_comb begin
        char_c = 8'h20;
        if (err_q) begin
            case (idx_q)
                3'd2:       char_c = 8'h45;
                3'd3, 3'd4: char_c = 8'h52;
                default:    char_c = 8'h20;
            endcase
        end else begin
            case (idx_q)
                3'd0:    char_c = neg_q ? 8'h2D : 8'h2B;
                3'd1:    char_c = (dd_q[19:16] != 4'd0) ? 8'h30 + {4'h0, dd_q[19:16]} : 8'h20;
                3'd2:    char_c = (dd_q[19:12] == 8'd0) ? 8'h20 : 8'h30 + {4'h0, dd_q[15:12]};
                3'd3:    char_c = 8'h30 + {4'h0, dd_q[11:8]};
                3'd4:    char_c = 8'h2E;
                3'd5:    char_c = frac_q ? 8'h35 : 8'h30;
                default: char_c = 8'h43;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        poll_d  = (poll_q == POLL_MAX) ? poll_q : poll_q + PCW'(1);
        idx_d   = idx_q;
        msb_d   = msb_q;
        dd_d    = dd_q;
        neg_d   = neg_q;
        frac_d  = frac_q;
        err_d   = err_q;
        abort_d = abort_q;
        temp_d  = temp_q;
        serr_d  = serr_q;
        addr_d  = addr_q;
        go_d    = 1'b0;
        lcdw_d  = 1'b0;
        done_d  = 1'b0;
        wadd_d  = wadd_q;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                poll_d = '0;
                if (Controller_Enable) state_d = S_START;
            end
            S_WAIT: begin
                if (!Controller_Enable) begin
                    state_d = S_IDLE;
                end else if (poll_q >= POLL_LAST) begin
                    poll_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!Controller_Enable) begin
                    state_d = S_IDLE;
                end else if (Master_Ready) begin
                    go_d    = 1'b1;
                    addr_d  = Menu_SlaveAddr;
                    abort_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_BYTE0;
                end
            end
            S_BYTE0: begin
                if (!Controller_Enable) abort_d = 1'b1;
                if (Master_Done) begin
                    if (Master_ACK) begin
                        state_d = S_ERR_WAIT;
                    end else begin
                        msb_d   = Master_ReadData;
                        state_d = S_BYTE1;
                    end
                end
`ifdef TEMP_WATCHDOG_EN
                else if (wdog_q == WDOG_LAST) state_d = S_ERR_WAIT;
`endif
            end
            S_BYTE1: begin
                if (!Controller_Enable) abort_d = 1'b1;
                if (Master_Done) begin
                    if (Master_ACK) begin
                        state_d = S_ERR_WAIT;
                    end else if (abort_q || !Controller_Enable) begin
                        state_d = S_IDLE;
                    end else begin
                        temp_d  = raw_c;
                        serr_d  = 1'b0;
                        neg_d   = raw_c[8] && (abs_c != 9'd0);
                        frac_d  = abs_c[0];
                        dd_d    = {12'd0, abs_c[8:1]};
                        idx_d   = 3'd0;
                        state_d = S_CONV;
                    end
                end
`ifdef TEMP_WATCHDOG_EN
                else if (wdog_q == WDOG_LAST) state_d = S_ERR_WAIT;
`endif
            end
            S_CONV: begin
                if (!Controller_Enable) abort_d = 1'b1;
                dd_d  = dd_step(dd_q);
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = (abort_q || !Controller_Enable) ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                lcdw_d = 1'b1;
                wadd_d = LCD_BASE + 5'(idx_q);
                din_d  = char_c;
                idx_d  = idx_q + 3'd1;
                if (idx_q == 3'd6) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = Controller_Enable ? S_WAIT : S_IDLE;
            end
            S_ERR_WAIT: begin
                if (!Controller_Enable) abort_d = 1'b1;
                if (Master_Ready) begin
                    if (abort_q || !Controller_Enable) begin
                        state_d = S_IDLE;
                    end else begin
                        serr_d  = 1'b1;
                        err_d   = 1'b1;
                        idx_d   = 3'd0;
                        state_d = S_WRITE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Master command fields follow the state being entered so they align with Go
        nb_d   = (state_d == S_BYTE0 || state_d == S_BYTE1) ? 6'd2 : 6'd0;
        reg_d  = (state_d == S_BYTE0 || state_d == S_BYTE1) ? REG_PTR : 8'h00;
        stop_d = (state_d == S_BYTE1);
`ifdef TEMP_WATCHDOG_EN
        wdog_d = ((state_d == state_q) && (state_q == S_BYTE0 || state_q == S_BYTE1))
                 ? wdog_q + WDW'(1) : '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            poll_q  <= '0;
            idx_q   <= '0;
            msb_q   <= '0;
            dd_q    <= '0;
            neg_q   <= 1'b0;
            frac_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            temp_q  <= '0;
            serr_q  <= 1'b0;
            addr_q  <= '0;
            go_q    <= 1'b0;
            stop_q  <= 1'b0;
            lcdw_q  <= 1'b0;
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
            nb_q    <= '0;
            reg_q   <= '0;
            din_q   <= '0;
            wadd_q  <= '0;
`ifdef TEMP_WATCHDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            idx_q   <= idx_d;
            msb_q   <= msb_d;
            dd_q    <= dd_d;
            neg_q   <= neg_d;
            frac_q  <= frac_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            temp_q  <= temp_d;
            serr_q  <= serr_d;
            addr_q  <= addr_d;
            go_q    <= go_d;
            stop_q  <= stop_d;
            lcdw_q  <= lcdw_d;
            done_q  <= done_d;
            rw_q    <= 1'b1;
            nb_q    <= nb_d;
            reg_q   <= reg_d;
            din_q   <= din_d;
            wadd_q  <= wadd_d;
`ifdef TEMP_WATCHDOG_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    assign Master_Go           = go_q;
    assign Master_Stop         = stop_q;
    assign Master_RW           = rw_q;
    assign Master_NumOfBytes   = nb_q;
    assign Master_SlaveAddr    = addr_q;
    assign Master_SlaveRegAddr = reg_q;
    assign Master_DataWriteReg = 8'h00;
    assign LCD_WADD            = wadd_q;
    assign LCD_DIN             = din_q;
    assign LCD_W               = lcdw_q;
    assign Controller_Done     = done_q;
    assign temp_half           = temp_q;
    assign sensor_error        = serr_q;
endmodule
